// File: rtl/fwd_pkg.sv
// Shared types for the operand forwarding / load-use controller.
// Result-source select encodings, age-slot layout and sequencing FSM states.
package fwd_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_DM  = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b11;

    typedef logic [REG_AW-1:0] reg_addr_t;

    typedef struct packed {
        logic      v;
        reg_addr_t rd;
        logic      we;
        logic      ld;
    } slot_t;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fsm_state_t;

    function automatic logic slot_hit(input slot_t s, input reg_addr_t r);
        return s.v & s.we & (s.rd == r);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forwarding select: youngest in-flight writer of the operand wins.
// Purely combinational, no latency, no flow control.
// Also flags when the youngest writer is a load whose data is not yet available.
module fwd_sel
    import fwd_pkg::*;
(
    input  reg_addr_t   opnd,
    input  slot_t       s1,
    input  slot_t       s2,
    input  slot_t       s3,
    output logic [1:0]  sel,
    output logic        s1_load_hit
);

    always_comb begin
        sel = SEL_REG;
        if (slot_hit(s1, opnd)) begin
            sel = SEL_EX;
        end else if (slot_hit(s2, opnd)) begin
            sel = SEL_DM;
        end else if (slot_hit(s3, opnd)) begin
            sel = SEL_WB;
        end
        s1_load_hit = slot_hit(s1, opnd) & s1.ld;
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Operand-select sequencer: tracks 3 younger writers, drives bank selects, stalls one cycle on load-use.
// Selects/bubble registered (aligned with EX); stall is combinational in the decode cycle.
// Backpressure: stall holds PC/decode for one cycle; HAZ_STALL_CNT_EN adds a saturating stall counter.
module fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int AW = REG_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [AW-1:0] id_ra,
    input  logic [AW-1:0] id_rb,
    input  logic [AW-1:0] id_rd,
    input  logic          id_we,
    input  logic          id_load,
    input  logic          id_imm,
    input  logic          flush,
    output logic [1:0]    mux_sel_A,
    output logic [1:0]    mux_sel_B,
    output logic          imm_sel,
`ifdef HAZ_STALL_CNT_EN
    output logic [15:0]   stall_cnt,
`endif
    output logic          stall,
    output logic          bubble
);

    slot_t      s1_q, s2_q, s3_q;
    slot_t      s1_d, s2_d, s3_d;
    fsm_state_t state_q, state_d;
    logic [1:0] sel_a_q, sel_a_d, sel_b_q, sel_b_d;
    logic       imm_sel_q, imm_sel_d;
    logic       bubble_q, bubble_d;

    logic [1:0] sel_a, sel_b;
    logic       hit_a, hit_b;
    logic       id_live, load_use, issue;

    fwd_sel u_sel_a (
        .opnd        (reg_addr_t'(id_ra)),
        .s1          (s1_q),
        .s2          (s2_q),
        .s3          (s3_q),
        .sel         (sel_a),
        .s1_load_hit (hit_a)
    );

    fwd_sel u_sel_b (
        .opnd        (reg_addr_t'(id_rb)),
        .s1          (s1_q),
        .s2          (s2_q),
        .s3          (s3_q),
        .sel         (sel_b),
        .s1_load_hit (hit_b)
    );

    always_comb begin
        id_live  = id_valid & ~flush;
        load_use = id_live & (hit_a | (~id_imm & hit_b));
        // In HOLD the load has moved to s2, so the same load never stalls twice.
        stall    = (state_q == RUN) & load_use;
        issue    = id_live & ~stall;

        state_d = state_q;
        case (state_q)
            RUN:     if (stall) state_d = HOLD;
            HOLD:    state_d = RUN;
            default: state_d = RUN;
        endcase

        s3_d = s2_q;
        s2_d = s1_q;
        s1_d = '0;

        sel_a_d   = SEL_REG;
        sel_b_d   = SEL_REG;
        imm_sel_d = 1'b0;
        bubble_d  = 1'b1;

        if (issue) begin
            s1_d      = '{v: 1'b1, rd: reg_addr_t'(id_rd), we: id_we, ld: id_load};
            sel_a_d   = sel_a;
            sel_b_d   = id_imm ? SEL_REG : sel_b;
            imm_sel_d = id_imm;
            bubble_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            state_q   <= RUN;
            sel_a_q   <= SEL_REG;
            sel_b_q   <= SEL_REG;
            imm_sel_q <= 1'b0;
            bubble_q  <= 1'b1;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
            state_q   <= state_d;
            sel_a_q   <= sel_a_d;
            sel_b_q   <= sel_b_d;
            imm_sel_q <= imm_sel_d;
            bubble_q  <= bubble_d;
        end
    end

    assign mux_sel_A = sel_a_q;
    assign mux_sel_B = sel_b_q;
    assign imm_sel   = imm_sel_q;
    assign bubble    = bubble_q;

`ifdef HAZ_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: each step drives one decode slot and queues the
// EX-cycle selects it must produce; those are popped and compared after the next posedge.
module tb_fwd_hazard_ctrl;

    localparam logic [1:0] R = 2'b00;
    localparam logic [1:0] X = 2'b01;
    localparam logic [1:0] D = 2'b10;
    localparam logic [1:0] W = 2'b11;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_ra, id_rb, id_rd;
    logic       id_we, id_load, id_imm, flush;
    logic [1:0] mux_sel_A, mux_sel_B;
    logic       imm_sel, stall, bubble;
`ifdef HAZ_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    typedef struct packed {
        logic [1:0] a;
        logic [1:0] b;
        logic       imm;
        logic       bub;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   exp_stalls;

    fwd_hazard_ctrl #(.AW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .id_valid  (id_valid),
        .id_ra     (id_ra),
        .id_rb     (id_rb),
        .id_rd     (id_rd),
        .id_we     (id_we),
        .id_load   (id_load),
        .id_imm    (id_imm),
        .flush     (flush),
        .mux_sel_A (mux_sel_A),
        .mux_sel_B (mux_sel_B),
        .imm_sel   (imm_sel),
`ifdef HAZ_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .stall     (stall),
        .bubble    (bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One decode cycle: drive, check combinational stall mid-cycle, then check registered EX outputs.
    task automatic step(input logic r, input logic v,
                        input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd,
                        input logic we, input logic ld, input logic imm, input logic fl,
                        input logic xs, input logic [1:0] xa, input logic [1:0] xb,
                        input logic xi, input logic xbub);
        exp_t e;
        rst = r; id_valid = v; id_ra = ra; id_rb = rb; id_rd = rd;
        id_we = we; id_load = ld; id_imm = imm; flush = fl;
        exp_q.push_back('{a: xa, b: xb, imm: xi, bub: xbub});
        @(negedge clk);
        chk("stall", {15'd0, stall}, {15'd0, xs});
        if (r) exp_stalls = 0;
        else if (xs) exp_stalls++;
        @(posedge clk);
        #1;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_empty observed 0 expected 1");
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("mux_sel_A", {14'd0, mux_sel_A}, {14'd0, e.a});
            chk("mux_sel_B", {14'd0, mux_sel_B}, {14'd0, e.b});
            chk("imm_sel",   {15'd0, imm_sel},   {15'd0, e.imm});
            chk("bubble",    {15'd0, bubble},    {15'd0, e.bub});
        end
    endtask

    task automatic nop3();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, R, R, 0, 1);
    endtask

    task automatic wr(input logic [4:0] rd, input logic ld);
        step(0, 1, 5'd10, 5'd11, rd, 1, ld, 0, 0, 0, R, R, 0, 0);
    endtask

    initial begin
        checks = 0; errors = 0; exp_stalls = 0;

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, R, R, 0, 1);
`ifdef HAZ_STALL_CNT_EN
        chk("stall_cnt_reset", stall_cnt, 16'd0);
`endif

        // Forward from s1: ADD r3 ; SUB r5,r3,r4
        step(0, 1, 1, 2, 3, 1, 0, 0, 0, 0, R, R, 0, 0);
        step(0, 1, 3, 4, 5, 1, 0, 0, 0, 0, X, R, 0, 0);
        nop3();

        // Age priority: writers of r7 at ages 3,2,1
        wr(7, 0); wr(7, 0); wr(7, 0);
        step(0, 1, 7, 7, 8, 1, 0, 0, 0, 0, X, X, 0, 0);
        nop3();
        wr(7, 0); wr(7, 0); wr(9, 0);
        step(0, 1, 7, 7, 8, 1, 0, 0, 0, 0, D, D, 0, 0);
        nop3();
        wr(7, 0); wr(9, 0); wr(9, 0);
        step(0, 1, 7, 7, 8, 1, 0, 0, 0, 0, W, W, 0, 0);
        nop3();

        // Load-use: LD r2 ; ADD r6,r2,r1 stalls once then forwards from DM
        wr(2, 1);
        step(0, 1, 2, 1, 6, 1, 0, 0, 0, 1, R, R, 0, 1);
        step(0, 1, 2, 1, 6, 1, 0, 0, 0, 0, D, R, 0, 0);
        nop3();

        // Immediate masks the B-side hazard
        wr(2, 1);
        step(0, 1, 1, 2, 6, 1, 0, 1, 0, 0, R, R, 1, 0);
        nop3();

        // Flush wins over a hazard; the dependent then forwards from DM
        wr(2, 1);
        step(0, 1, 2, 1, 6, 1, 0, 0, 1, 0, R, R, 0, 1);
        step(0, 1, 2, 1, 6, 1, 0, 0, 0, 0, D, R, 0, 0);
        nop3();

        // Back-to-back loads, second depends on first, consumer depends on second
        wr(2, 1);
        step(0, 1, 2, 11, 4, 1, 1, 0, 0, 1, R, R, 0, 1);
        step(0, 1, 2, 11, 4, 1, 1, 0, 0, 0, D, R, 0, 0);
        step(0, 1, 4, 12, 6, 1, 0, 0, 0, 1, R, R, 0, 1);
        step(0, 1, 4, 12, 6, 1, 0, 0, 0, 0, D, R, 0, 0);
        nop3();

        // Register 0 forwards like any other register
        wr(0, 0);
        step(0, 1, 0, 0, 6, 1, 0, 0, 0, 0, X, X, 0, 0);
        nop3();

        // Reset while in HOLD
        wr(2, 1);
        step(0, 1, 2, 1, 6, 1, 0, 0, 0, 1, R, R, 0, 1);
`ifdef HAZ_STALL_CNT_EN
        chk("stall_cnt_count", stall_cnt, 16'(exp_stalls));
`endif
        step(1, 1, 2, 1, 6, 1, 0, 0, 0, 0, R, R, 0, 1);
`ifdef HAZ_STALL_CNT_EN
        chk("stall_cnt_cleared", stall_cnt, 16'd0);
`endif
        step(0, 1, 2, 1, 6, 1, 0, 0, 0, 0, R, R, 0, 0);

        // Three fresh hazards after reset
        for (int i = 0; i < 3; i++) begin
            nop3();
            wr(2, 1);
            step(0, 1, 2, 1, 6, 1, 0, 0, 0, 1, R, R, 0, 1);
            step(0, 1, 2, 1, 6, 1, 0, 0, 0, 0, D, R, 0, 0);
        end
`ifdef HAZ_STALL_CNT_EN
        chk("stall_cnt_three", stall_cnt, 16'(exp_stalls));
        chk("stall_cnt_is3", stall_cnt, 16'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
Sequencing controller for the register bank's operand-select path. It tracks the destination registers of the three instructions ahead of the consumer and drives the mux_sel_A, mux_sel_B and imm_sel inputs of the register bank. It detects load-use hazards and holds the front end for one cycle. It sits between the decode stage and the register bank/execute stage of the 16-bit pipelined core.

Parameters:
AW, 5, register address width (32 registers)

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous active-high reset
id_valid  input  1  decode slot holds a real instruction
id_ra  input  AW  source register A of the decode instruction
id_rb  input  AW  source register B of the decode instruction
id_rd  input  AW  destination register of the decode instruction
id_we  input  1  decode instruction writes id_rd
id_load  input  1  decode instruction is a load (result valid only from the DM stage)
id_imm  input  1  operand B is the immediate
flush  input  1  kill the decode instruction (branch taken)
mux_sel_A  output  2  register bank A select: 00 reg, 01 ans_ex, 10 ans_dm, 11 ans_wb
mux_sel_B  output  2  register bank B select, same encoding
imm_sel  output  1  register bank B immediate select
stall  output  1  hold PC and decode register this cycle (combinational)
bubble  output  1  EX stage holds an inserted no-op (registered)

Behaviour:
- Age slots s1/s2/s3 = {v, rd, we, ld} hold the instructions 1, 2 and 3 ahead of the instruction entering EX. Results: s1 on ans_ex, s2 on ans_dm, s3 on ans_wb. Older instructions are already in the register file.
- Issue condition: issue = id_valid & ~flush & ~stall.
- Each posedge: s3<=s2, s2<=s1, s1<=issue ? {1,id_rd,id_we,id_load} : 0.
- Issue registers, at the same posedge:
  - mux_sel_A/B and imm_sel update together with the bank's reg_A/reg_B capture, so they are aligned during EX.
  - Without issue: mux_sel_A=mux_sel_B=00, imm_sel=0, bubble<=1.
  - With issue: bubble<=0.
- Match rule for operand X (ra or rb): match_k = sk.v & sk.we & (sk.rd==X).
- Select priority is youngest first: s1 gives 01, else s2 gives 10, else s3 gives 11, else 00.
- Operand B with id_imm=1: imm_sel=1, mux_sel_B=00, and no hazard is checked on rb.
- Load-use hazard (combinational): id_valid & ~flush & s1.v & s1.ld & s1.we & ((s1.rd==id_ra) | (~id_imm & s1.rd==id_rb)).
- FSM states:
  - RUN: a hazard asserts stall and moves to HOLD.
  - HOLD: stall=0. The load is now in s2, so forwarding selects 10. Always returns to RUN.
  - A hazard is never raised twice for the same load.
- Back-to-back loads with a dependency on the second load: that load is handled by the same rule on the next decode.
- flush with a hazard: flush wins. No stall, bubble inserted, and the FSM stays in RUN.
- Reset values: s1..s3 cleared, FSM=RUN, mux_sel_A=mux_sel_B=00, imm_sel=0, bubble=1, stall=0.
- Reset mid-stall returns to RUN with all slots invalid.
- Register 0 has no special meaning; it is forwarded like any other register.

Optional Feature:
HAZ_STALL_CNT_EN
- Defined:
  - Adds output stall_cnt [15:0], the count of cycles with stall=1.
  - Saturates at 16'hFFFF.
  - Cleared by rst.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Shared package fwd_pkg holds:
  - SEL_REG=2'b00, SEL_EX=2'b01, SEL_DM=2'b10, SEL_WB=2'b11
  - the slot struct/field widths
  - FSM state encoding RUN/HOLD
- One natural sub-module, fwd_sel. It is combinational, instanced twice (A and B), and maps (operand, s1..s3) to {sel, s1_load_hit}.

Test Plan:
- Forward from s1: ADD r3 then SUB r5,r3,r4 -> SUB enters EX with mux_sel_A=01, mux_sel_B=00, stall never 1.
- Age priority: writes r7 at ages 3, 2 and 1, then consumer uses r7 on both A and B -> sel=01 on both. With only the age-3 and age-2 writes -> sel=10. With only the age-3 write -> 11.
- Load-use: LD r2, then ADD r6,r2,r1 -> stall=1 for exactly 1 cycle, bubble=1 in the following EX cycle, then ADD in EX with mux_sel_A=10.
- Immediate masks B hazard: LD r2, then ADDI r6,r1,#5 with id_rb=2 -> no stall, imm_sel=1, mux_sel_B=00.
- Flush priority: load-use hazard with flush=1 in the same cycle -> stall=0, bubble=1, FSM in RUN. Next dependent instruction forwards from 10 with no stall.
- Reset during HOLD: rst=1 for one cycle -> all selects 00, imm_sel=0, bubble=1. First post-reset instruction using r2 gets sel 00. With HAZ_STALL_CNT_EN: stall_cnt=0, and 3 hazards give stall_cnt=3.
